// File: rtl/count_ones_sequential_pkg.sv
// Package shared by the sequential population counter and its sub-module.
//   state_t : FSM state encoding (IDLE=0, COUNT=1, DONE=2), also seen on the
//             debug state port of count_ones_sequential.
package count_ones_sequential_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_COUNT = 2'd1,
    STATE_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/count_ones_sequential_count_ones.sv
// count_ones: combinational population count of one WIDTH-bit chunk.
// Ports:
//   data   in  WIDTH       chunk to count
//   count  out WIDTH_LOG2  number of set bits in data (0..WIDTH)
module count_ones #(
  parameter int WIDTH      = 8,
  parameter int WIDTH_LOG2 = 4
) (
  input  logic [WIDTH-1:0]      data,
  output logic [WIDTH_LOG2-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + WIDTH_LOG2'(data[i]);
    end
  end

endmodule

// File: rtl/count_ones_sequential.sv
// count_ones_sequential: multi-cycle population counter for wide vectors.
// One WIDTH-bit word is accepted, then counted CHUNK_WIDTH bits per cycle
// through a single count_ones instance; the total is returned afterwards.
//
// Ports:
//   clock         in   1            rising-edge clock
//   resetn        in   1            asynchronous reset, active-low
//   input_valid   in   1            input_data is valid
//   input_ready   out  1            block can accept a word (IDLE)
//   input_data    in   WIDTH        vector to count
//   output_valid  out  1            output_count is valid (DONE)
//   output_ready  in   1            consumer accepts output_count
//   output_count  out  COUNT_WIDTH  set bits of the accepted word, 0 outside DONE
//   busy          out  1            transaction in progress (state != IDLE)
//   dbg_state     out  2            current FSM state (IDLE=0, COUNT=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ready does not depend on valid; once output_valid rises the
// count is held stable until output_ready is seen. input_valid outside IDLE
// is ignored, so input and output never overlap.
//
// Build option: define COUNT_ONES_SEQUENTIAL_EARLY_EXIT_EN to leave COUNT as
// soon as no set bits remain in the shift register (variable latency,
// same result). Without it the COUNT phase is always NUM_CHUNKS cycles.
module count_ones_sequential
  import count_ones_sequential_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int CHUNK_WIDTH       = 8,
  parameter int NUM_CHUNKS        = WIDTH / CHUNK_WIDTH,
  parameter int COUNT_WIDTH       = $clog2(WIDTH + 1),
  parameter int CHUNK_COUNT_WIDTH = $clog2(CHUNK_WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [WIDTH-1:0]       input_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [COUNT_WIDTH-1:0] output_count,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int IDX_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
    $error("count_ones_sequential: WIDTH must be a multiple of CHUNK_WIDTH");
  end

  state_t                       state_q, state_d;
  logic [WIDTH-1:0]             shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]       acc_q, acc_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_count;
  logic [WIDTH-1:0]             shift_next;
  logic                         last_chunk;
  logic                         count_done;

  count_ones #(
    .WIDTH      (CHUNK_WIDTH),
    .WIDTH_LOG2 (CHUNK_COUNT_WIDTH)
  ) u_count_ones (
    .data  (shift_q[CHUNK_WIDTH-1:0]),
    .count (chunk_count)
  );

  assign shift_next = shift_q >> CHUNK_WIDTH;
  assign last_chunk = (idx_q == IDX_WIDTH'(NUM_CHUNKS - 1));

`ifdef COUNT_ONES_SEQUENTIAL_EARLY_EXIT_EN
  // Nothing left to count once the remaining bits are all zero.
  assign count_done = last_chunk || (shift_next == '0);
`else
  assign count_done = last_chunk;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= STATE_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      STATE_IDLE: begin
        if (input_valid) begin
          shift_d = input_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = STATE_COUNT;
        end
      end
      STATE_COUNT: begin
        // Chunk count is zero-extended; acc cannot exceed WIDTH.
        acc_d   = acc_q + COUNT_WIDTH'(chunk_count);
        shift_d = shift_next;
        idx_d   = idx_q + IDX_WIDTH'(1);
        if (count_done) begin
          state_d = STATE_DONE;
        end
      end
      STATE_DONE: begin
        if (output_ready) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  assign input_ready  = (state_q == STATE_IDLE);
  assign output_valid = (state_q == STATE_DONE);
  assign output_count = (state_q == STATE_DONE) ? acc_q : '0;
  assign busy         = (state_q != STATE_IDLE);
  assign dbg_state    = state_q;

endmodule
